// File: rtl/snake_body_engine.sv
// Snake body engine: circular segment buffer, tick-driven step, collision check, CELL x CELL pixel streaming.
// Step latency 1+length cycles to first pixel; ticks outside IDLE are dropped. WRAP_EN makes the grid toroidal.
module snake_body_engine #(
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 6,
    parameter int CELL     = 4,
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int X_W      = 8,
    parameter int Y_W      = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           tick,
    input  logic [1:0]     dir,
    input  logic [5:0]     food_x,
    input  logic [4:0]     food_y,
    output logic [X_W-1:0] plot_x,
    output logic [Y_W-1:0] plot_y,
    output logic [2:0]     plot_colour,
    output logic           plot_en,
    output logic           busy,
    output logic           ate,
    output logic           dead,
    output logic [5:0]     length
);
    localparam int IW = $clog2(MAX_LEN);
    localparam int CW = $clog2(CELL);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_CHECK, S_ERASE, S_DRAW, S_DEAD} state_t;

    state_t          state, nstate;
    logic [5:0]      seg_x [MAX_LEN];
    logic [4:0]      seg_y [MAX_LEN];
    logic [IW-1:0]   hp, hp_n, rd_idx, tail_idx;
    logic [5:0]      len, cnt;
    logic [1:0]      heading, new_heading;
    logic [2*CW-1:0] pix;
    logic [5:0]      nx_q, nx, cx;
    logic [4:0]      ny_q, ny, cy;
    logic            grow_q, off, eat, hit, draw_on, last_pix;
    logic [2:0]      colour_n;
    logic signed [7:0] tx, ty;

    function automatic logic [IW-1:0] idx_add(input logic [IW-1:0] base, input logic [5:0] ofs);
        int s;
        s = (int'(base) + int'(ofs)) % MAX_LEN;
        return IW'(s);
    endfunction

    assign length   = len;
    assign last_pix = &pix;
    assign tail_idx = idx_add(hp, len - 6'd1);
    assign rd_idx   = (state == S_ERASE) ? tail_idx : idx_add(hp, cnt);
    assign hp_n     = (hp == '0) ? IW'(MAX_LEN - 1) : hp - 1'b1;
    assign cx       = (state == S_DRAW) ? nx_q : seg_x[rd_idx];
    assign cy       = (state == S_DRAW) ? ny_q : seg_y[rd_idx];
    assign hit      = (seg_x[rd_idx] == nx_q) && (seg_y[rd_idx] == ny_q) &&
                      (grow_q || cnt != len - 6'd1);

    // Reversal requests keep the current heading.
    always_comb begin
        new_heading = dir;
        if (dir[1] == heading[1] && dir[0] != heading[0])
            new_heading = heading;
        tx = $signed({2'b00, seg_x[hp]});
        ty = $signed({3'b000, seg_y[hp]});
        case (new_heading)
            2'd0: tx = tx - 8'sd1;
            2'd1: tx = tx + 8'sd1;
            2'd2: ty = ty - 8'sd1;
            2'd3: ty = ty + 8'sd1;
        endcase
`ifdef WRAP_EN
        off = 1'b0;
        if (tx < 8'sd0)              tx = 8'(GRID_W - 1);
        else if (tx >= 8'(GRID_W))   tx = 8'sd0;
        if (ty < 8'sd0)              ty = 8'(GRID_H - 1);
        else if (ty >= 8'(GRID_H))   ty = 8'sd0;
`else
        off = (tx < 8'sd0) || (tx >= 8'(GRID_W)) || (ty < 8'sd0) || (ty >= 8'(GRID_H));
`endif
        nx  = 6'(tx);
        ny  = 5'(ty);
        eat = (nx == food_x) && (ny == food_y);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_INIT;
        else         state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            S_INIT:  if (last_pix && cnt == 6'(INIT_LEN - 1)) nstate = S_IDLE;
            S_IDLE:  if (tick) nstate = off ? S_DEAD : S_CHECK;
            S_CHECK: begin
                if (hit)                       nstate = S_DEAD;
                else if (cnt == len - 6'd1)    nstate = grow_q ? S_DRAW : S_ERASE;
            end
            S_ERASE: if (last_pix) nstate = S_DRAW;
            S_DRAW:  if (last_pix) nstate = S_IDLE;
            S_DEAD:  nstate = S_DEAD;
            default: nstate = S_INIT;
        endcase
    end

    // busy stays high through the trailing registered pixel.
    always_comb begin
        draw_on  = (state == S_INIT) || (state == S_ERASE) || (state == S_DRAW);
        colour_n = (state == S_ERASE) ? 3'b000 : 3'b010;
        dead     = (state == S_DEAD);
        busy     = ((state != S_IDLE) && (state != S_DEAD)) || plot_en;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? 6'(GRID_W / 2 - i) : 6'd0;
                seg_y[i] <= (i < INIT_LEN) ? 5'(GRID_H / 2) : 5'd0;
            end
            hp          <= '0;
            len         <= 6'(INIT_LEN);
            heading     <= 2'd1;
            cnt         <= '0;
            pix         <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            grow_q      <= 1'b0;
            ate         <= 1'b0;
            plot_en     <= 1'b0;
            plot_x      <= '0;
            plot_y      <= '0;
            plot_colour <= '0;
        end else begin
            ate     <= 1'b0;
            plot_en <= draw_on;
            if (draw_on) begin
                plot_x      <= X_W'({cx, pix[CW-1:0]});
                plot_y      <= Y_W'({cy, pix[2*CW-1:CW]});
                plot_colour <= colour_n;
            end
            case (state)
                S_INIT: begin
                    pix <= pix + 1'b1;
                    if (last_pix) cnt <= (cnt == 6'(INIT_LEN - 1)) ? 6'd0 : cnt + 6'd1;
                end
                S_IDLE: begin
                    if (tick && !off) begin
                        heading <= new_heading;
                        nx_q    <= nx;
                        ny_q    <= ny;
                        grow_q  <= eat && (len < 6'(MAX_LEN));
                        ate     <= eat;
                        cnt     <= '0;
                    end
                end
                S_CHECK: begin
                    cnt <= cnt + 6'd1;
                    pix <= '0;
                end
                S_ERASE: pix <= pix + 1'b1;
                S_DRAW: begin
                    pix <= pix + 1'b1;
                    if (last_pix) begin
                        hp           <= hp_n;
                        seg_x[hp_n]  <= nx_q;
                        seg_y[hp_n]  <= ny_q;
                        if (grow_q) len <= len + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_snake_body_engine.sv
// Directed bench for snake_body_engine: init draw, step, reversal, growth, wall, self-collision, restart.
module tb_snake_body_engine;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       tick = 1'b0;
    logic [1:0] dir = 2'd0;
    logic [5:0] food_x = 6'd0;
    logic [4:0] food_y = 5'd0;
    logic [7:0] plot_x;
    logic [6:0] plot_y;
    logic [2:0] plot_colour;
    logic       plot_en, busy, ate, dead;
    logic [5:0] length;

    snake_body_engine dut (
        .clk(clk), .resetn(resetn), .tick(tick), .dir(dir),
        .food_x(food_x), .food_y(food_y),
        .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour), .plot_en(plot_en),
        .busy(busy), .ate(ate), .dead(dead), .length(length)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc = 0;
    int qx[$], qy[$], qc[$], qt[$];
    int busy_cnt = 0, ate_cnt = 0, ate_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn) begin
            if (plot_en) begin
                qx.push_back(int'(plot_x));
                qy.push_back(int'(plot_y));
                qc.push_back(int'(plot_colour));
                qt.push_back(cyc);
            end
            if (busy) busy_cnt++;
            if (ate) begin
                ate_cnt++;
                ate_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_px(input string tag, input int k, input int ex, input int ey, input int ec);
        chk({tag, "_x"}, (k < qx.size()) ? qx[k] : -1, ex);
        chk({tag, "_y"}, (k < qy.size()) ? qy[k] : -1, ey);
        chk({tag, "_c"}, (k < qc.size()) ? qc[k] : -1, ec);
    endtask

    task automatic clear_mon();
        qx.delete(); qy.delete(); qc.delete(); qt.delete();
        busy_cnt = 0; ate_cnt = 0; ate_cyc = -1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk({tag, "_timeout"}, n, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        clear_mon();
        resetn = 1'b1;
        wait_idle("init");
    endtask

    task automatic do_tick(input logic [1:0] d);
        @(negedge clk);
        clear_mon();
        tick = 1'b1;
        dir  = d;
        acc  = cyc + 1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_plot_en", int'(plot_en), 0);
        chk("rst_plot_x", int'(plot_x), 0);
        chk("rst_plot_y", int'(plot_y), 0);
        chk("rst_colour", int'(plot_colour), 0);
        chk("rst_ate", int'(ate), 0);
        chk("rst_dead", int'(dead), 0);
        chk("rst_length", int'(length), 6);
        chk("rst_busy", int'(busy), 1);
        clear_mon();
        resetn = 1'b1;
        wait_idle("init");
        chk("init_count", qx.size(), 96);
        chk_px("init_first", 0, 80, 60, 2);
        chk_px("init_seg1", 16, 76, 60, 2);
        chk_px("init_last", 95, 63, 63, 2);
        chk("init_contig", (qt.size() == 96) ? qt[95] - qt[0] : -1, 95);
        chk("init_busy", int'(busy), 0);
        chk("init_length", int'(length), 6);

        // Plain step right; a tick arriving mid-step is dropped
        do_tick(2'd1);
        repeat (3) @(negedge clk);
        tick = 1'b1; dir = 2'd3;
        @(negedge clk);
        tick = 1'b0;
        wait_idle("step");
        repeat (20) @(negedge clk);
        chk("step_count", qx.size(), 32);
        chk("step_latency", (qt.size() > 0) ? qt[0] - acc : -1, 7);
        chk("step_busy", busy_cnt, 39);
        chk_px("erase_first", 0, 60, 60, 0);
        chk_px("erase_last", 15, 63, 63, 0);
        chk_px("draw_first", 16, 84, 60, 2);
        chk_px("draw_last", 31, 87, 63, 2);
        chk("step_length", int'(length), 6);
        chk("step_no_ate", ate_cnt, 0);
        do_tick(2'd1);
        wait_idle("step2");
        chk_px("step2_draw", 16, 88, 60, 2);

        // Reversal ignored
        do_reset();
        do_tick(2'd0);
        wait_idle("rev");
        chk_px("rev_draw", 16, 84, 60, 2);

        // Eat food and grow
        do_reset();
        food_x = 6'd21; food_y = 5'd15;
        do_tick(2'd1);
        wait_idle("grow");
        food_x = 6'd0; food_y = 5'd0;
        chk("grow_ate_cnt", ate_cnt, 1);
        chk("grow_ate_cyc", ate_cyc - acc, 0);
        chk("grow_count", qx.size(), 16);
        chk_px("grow_draw", 0, 84, 60, 2);
        chk("grow_latency", (qt.size() > 0) ? qt[0] - acc : -1, 7);
        chk("grow_busy", busy_cnt, 23);
        chk("grow_length", int'(length), 7);

        // Wall: 15 steps up reach row 0, the 16th leaves the grid
        do_reset();
        for (int i = 1; i <= 15; i++) begin
            do_tick(2'd2);
            wait_idle("up");
        end
        chk_px("top_draw", 16, 80, 0, 2);
        chk("top_dead", int'(dead), 0);
        do_tick(2'd2);
        wait_idle("wall");
        repeat (5) @(negedge clk);
`ifdef WRAP_EN
        chk("wrap_dead", int'(dead), 0);
        chk_px("wrap_draw", 16, 80, 116, 2);
        chk_px("wrap_last", 31, 83, 119, 2);
`else
        chk("wall_dead", int'(dead), 1);
        chk("wall_noplot", qx.size(), 0);
        chk("wall_busy", int'(busy), 0);
`endif

        // Self collision: right, down, left, up into the body
        do_reset();
        do_tick(2'd1); wait_idle("sc1");
        do_tick(2'd3); wait_idle("sc2");
        do_tick(2'd0); wait_idle("sc3");
        chk_px("sc3_draw", 16, 80, 64, 2);
        do_tick(2'd2); wait_idle("sc4");
        repeat (5) @(negedge clk);
        chk("sc_dead", int'(dead), 1);
        chk("sc_noplot", qx.size(), 0);
        chk("sc_length", int'(length), 6);
        do_tick(2'd1);
        repeat (40) @(negedge clk);
        chk("dead_tick_noplot", qx.size(), 0);
        chk("dead_sticky", int'(dead), 1);
        chk("dead_busy", int'(busy), 0);

        // Restart after reset
        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        chk("restart_dead", int'(dead), 0);
        chk("restart_busy", int'(busy), 1);
        clear_mon();
        resetn = 1'b1;
        wait_idle("restart");
        chk("restart_count", qx.size(), 96);
        chk_px("restart_first", 0, 80, 60, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
